ft_tmr_error_manager: RTL and testbench

- Central fault manager for the TMR-protected blocks of the fault-tolerant core.
- Collects per-replica voter error flags and keeps a leaky error counter per replica.
- Declares a replica permanently faulty once its counter reaches a threshold.
- Schedules replica resynchronisation requests one at a time, round-robin, over a req/ack handshake to the replicated blocks.

---
 rtl/ft_mgr_pkg.sv | 20 ++
 rtl/ft_rr_arbiter.sv | 33 +++
 rtl/ft_tmr_error_manager.sv | 219 +++++++++++++++++++++
 tb/tb_ft_tmr_error_manager.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_mgr_pkg.sv
// Shared types and index helpers for the TMR fault manager.
// Replica signals are flattened as index 3*block + replica throughout.
package ft_mgr_pkg;

  localparam int N_REP = 3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mgr_state_e;

  function automatic int idx_to_blk(input int idx);
    return idx / N_REP;
  endfunction

  function automatic int idx_to_rep(input int idx);
    return idx % N_REP;
  endfunction

endpackage

// File: rtl/ft_rr_arbiter.sv
// Round-robin priority picker: grants the first set request at or after
// ptr_i, wrapping around; purely combinational.
module ft_rr_arbiter #(
  parameter int N     = 12,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  int               idx;
  logic [IDX_W-1:0] sel;

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (req_i[sel]) begin
        gnt_idx_o   = sel;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft_tmr_error_manager.sv
// Fault manager for TMR blocks: leaky per-replica error counters, sticky fault
// flags and round-robin resync scheduling. Macro FT_RESYNC_TIMEOUT_EN adds an ack timeout.
module ft_tmr_error_manager
  import ft_mgr_pkg::*;
#(
  parameter int N_BLK       = 4,
  parameter int CNT_W       = 4,
  parameter int ERR_THR     = 8,
  parameter int LEAK_PERIOD = 1024,
  parameter int RESYNC_TMO  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REP*N_BLK-1:0] err_i,
  input  logic                   clear_i,
  output logic [N_BLK-1:0]       resync_req_o,
  output logic [1:0]             resync_rep_o,
  input  logic                   resync_ack_i,
  output logic [N_REP*N_BLK-1:0] replica_en_o,
  output logic [N_REP*N_BLK-1:0] fault_perm_o,
  output logic [N_BLK-1:0]       uncorr_o,
  output logic                   irq_o
);

  localparam int N_IDX  = N_REP * N_BLK;
  localparam int IDX_W  = (N_IDX > 1) ? $clog2(N_IDX) : 1;
  localparam int LEAK_W = $clog2(LEAK_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(ERR_THR);

  if (ERR_THR < 1 || ERR_THR > (2 ** CNT_W) - 1 || LEAK_PERIOD < 2 || RESYNC_TMO < 1)
  begin : g_bad_params
    $error("ft_tmr_error_manager: illegal parameter combination");
  end

  logic [CNT_W-1:0]  cnt_q [N_IDX];
  logic [CNT_W-1:0]  cnt_d [N_IDX];
  logic [N_IDX-1:0]  pend_q, pend_d;
  logic [N_IDX-1:0]  fault_q, fault_d;
  logic [N_BLK-1:0]  uncorr_q, uncorr_d;
  logic              irq_q, irq_d;
  logic [LEAK_W-1:0] leak_q, leak_d;

  mgr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [N_IDX-1:0]  err_eff;
  logic [N_BLK-1:0]  multi_err;
  logic [N_IDX-1:0]  thr_hit;
  logic [N_IDX-1:0]  tmo_vec;
  logic              leak_tick;
  logic              ack_fire;
  logic              tmo_expire;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [IDX_W-1:0]  grant_next;

  ft_rr_arbiter #(
    .N     (N_IDX),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i       (pend_q),
    .ptr_i       (ptr_q),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // Faulted replicas no longer count, and a clear cycle discards all errors.
  always_comb begin
    err_eff   = clear_i ? '0 : (err_i & ~fault_q);
    multi_err = '0;
    for (int b = 0; b < N_BLK; b++) begin
      multi_err[b] = (err_eff[N_REP*b]     & err_eff[N_REP*b + 1]) |
                     (err_eff[N_REP*b]     & err_eff[N_REP*b + 2]) |
                     (err_eff[N_REP*b + 1] & err_eff[N_REP*b + 2]);
    end
  end

  always_comb begin
    leak_tick = (leak_q == LEAK_W'(LEAK_PERIOD - 1));
    leak_d    = leak_tick ? '0 : leak_q + LEAK_W'(1);
    ack_fire  = (state_q == REQ) && resync_ack_i && !clear_i;
  end

`ifdef FT_RESYNC_TIMEOUT_EN
  localparam int TMO_W = $clog2(RESYNC_TMO + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_expire = (state_q == REQ) && !resync_ack_i && !clear_i &&
                 (tmo_q == TMO_W'(RESYNC_TMO - 1));
    tmo_d      = (state_q == REQ && state_d == REQ) ? tmo_q + TMO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  always_comb begin
    tmo_expire = 1'b0;
  end
`endif

  always_comb begin
    tmo_vec = tmo_expire ? (N_IDX'(1) << grant_q) : '0;
  end

  // Increment and leak cancel out; the threshold test looks at the next value.
  always_comb begin
    for (int i = 0; i < N_IDX; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (err_eff[i] && !leak_tick) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
      end else if (!err_eff[i] && leak_tick && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      thr_hit[i] = !clear_i && !fault_q[i] && (cnt_d[i] >= CNT_THR);
    end
  end

  // A fresh error beats the ack of the same replica; faulting beats both.
  always_comb begin
    for (int i = 0; i < N_IDX; i++) begin
      pend_d[i] = pend_q[i];
      if (clear_i || thr_hit[i] || tmo_vec[i]) begin
        pend_d[i] = 1'b0;
      end else if (err_eff[i] && !multi_err[idx_to_blk(i)]) begin
        pend_d[i] = 1'b1;
      end else if (ack_fire && grant_q == IDX_W'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    fault_d  = clear_i ? '0 : (fault_q | thr_hit | tmo_vec);
    uncorr_d = clear_i ? '0 : (uncorr_q | multi_err);
    irq_d    = (|(fault_d & ~fault_q)) | (|(uncorr_d & ~uncorr_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IDX; i++) cnt_q[i] <= '0;
      pend_q   <= '0;
      fault_q  <= '0;
      uncorr_q <= '0;
      irq_q    <= 1'b0;
      leak_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      fault_q  <= fault_d;
      uncorr_q <= uncorr_d;
      irq_q    <= irq_d;
      leak_q   <= leak_d;
    end
  end

  always_comb begin
    grant_next = (grant_q == IDX_W'(N_IDX - 1)) ? '0 : grant_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Leaving REQ always forces a full IDLE cycle before the next grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = REQ;
          grant_d = arb_idx;
        end
      end
      REQ: begin
        if (ack_fire || tmo_expire) begin
          state_d = IDLE;
          ptr_d   = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    resync_req_o = '0;
    resync_rep_o = '0;
    if (state_q == REQ) begin
      resync_req_o = N_BLK'(1) << idx_to_blk(int'(grant_q));
      resync_rep_o = 2'(idx_to_rep(int'(grant_q)));
    end
  end

  always_comb begin
    replica_en_o = ~fault_q;
    fault_perm_o = fault_q;
    uncorr_o     = uncorr_q;
    irq_o        = irq_q;
  end

endmodule

// File: tb/tb_ft_tmr_error_manager.sv
// Directed bench for ft_tmr_error_manager with default parameters; the
// timeout section follows FT_RESYNC_TIMEOUT_EN.
module tb_ft_tmr_error_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] err_i = '0;
  logic        clear_i = 1'b0;
  logic        resync_ack_i = 1'b0;
  logic [3:0]  resync_req_o;
  logic [1:0]  resync_rep_o;
  logic [11:0] replica_en_o;
  logic [11:0] fault_perm_o;
  logic [3:0]  uncorr_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_irq;
  int n_miss;
  logic [3:0] seen_req;

  ft_tmr_error_manager dut (
    .clk          (clk),
    .rst          (rst),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .resync_req_o (resync_req_o),
    .resync_rep_o (resync_rep_o),
    .resync_ack_i (resync_ack_i),
    .replica_en_o (replica_en_o),
    .fault_perm_o (fault_perm_o),
    .uncorr_o     (uncorr_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [11:0] err, input logic clr, input logic ack);
    err_i        = err;
    clear_i      = clr;
    resync_ack_i = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    checkOutput("rst_req",    32'(resync_req_o), 32'h0);
    checkOutput("rst_rep",    32'(resync_rep_o), 32'h0);
    checkOutput("rst_en",     32'(replica_en_o), 32'hFFF);
    checkOutput("rst_fault",  32'(fault_perm_o), 32'h0);
    checkOutput("rst_uncorr", 32'(uncorr_o),     32'h0);
    checkOutput("rst_irq",    32'(irq_o),        32'h0);

    // Single error on block 1 replica 1
    $display("[TB] single error");
    applyStimulus(12'h010, 1'b0, 1'b0);
    checkOutput("t1_req_early", 32'(resync_req_o), 32'h0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("t1_req", 32'(resync_req_o), 32'b0010);
    checkOutput("t1_rep", 32'(resync_rep_o), 32'd1);
    repeat (3) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("t1_hold_req", 32'(resync_req_o), 32'b0010);
    checkOutput("t1_hold_rep", 32'(resync_rep_o), 32'd1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("t1_drop", 32'(resync_req_o), 32'h0);
    seen_req = '0;
    repeat (4) begin
      applyStimulus('0, 1'b0, 1'b1);
      seen_req |= resync_req_o;
    end
    checkOutput("t1_no_regrant", 32'(seen_req), 32'h0);

    // Threshold on block 0 replica 2, acks held high throughout
    $display("[TB] threshold");
    doReset();
    n_irq = 0;
    for (int p = 1; p <= 8; p++) begin
      applyStimulus(12'h004, 1'b0, 1'b1);
      if (irq_o) n_irq++;
      if (p == 7) checkOutput("thr_not_yet", 32'(fault_perm_o), 32'h0);
      if (p == 8) checkOutput("thr_irq", 32'(irq_o), 32'h1);
      applyStimulus('0, 1'b0, 1'b1);
      if (irq_o) n_irq++;
    end
    checkOutput("thr_fault", 32'(fault_perm_o), 32'h004);
    checkOutput("thr_en",    32'(replica_en_o), 32'hFFB);
    checkOutput("thr_irq_count", 32'(n_irq), 32'd1);
    repeat (4) applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(12'h004, 1'b0, 1'b0);
    seen_req = '0;
    n_irq = 0;
    repeat (5) begin
      applyStimulus('0, 1'b0, 1'b0);
      seen_req |= resync_req_o;
      if (irq_o) n_irq++;
    end
    checkOutput("thr_ignored_req", 32'(seen_req), 32'h0);
    checkOutput("thr_ignored_irq", 32'(n_irq), 32'd0);

    // Leak: 3 errors fully drained by three leak periods
    $display("[TB] leak");
    doReset();
    repeat (3) begin
      applyStimulus(12'h080, 1'b0, 1'b1);
      applyStimulus('0, 1'b0, 1'b1);
    end
    repeat (3 * 1024) applyStimulus('0, 1'b0, 1'b1);
    repeat (7) begin
      applyStimulus(12'h080, 1'b0, 1'b1);
      applyStimulus('0, 1'b0, 1'b1);
    end
    checkOutput("leak_no_fault", 32'(fault_perm_o), 32'h0);
    applyStimulus(12'h080, 1'b0, 1'b1);
    checkOutput("leak_eighth_fault", 32'(fault_perm_o), 32'h080);
    checkOutput("leak_eighth_irq",   32'(irq_o),        32'h1);
    repeat (4) applyStimulus('0, 1'b0, 1'b1);

    // Uncorrectable: two replicas of block 2 in one cycle
    $display("[TB] uncorrectable");
    doReset();
    applyStimulus(12'h0C0, 1'b0, 1'b0);
    checkOutput("unc_flag", 32'(uncorr_o), 32'b0100);
    checkOutput("unc_irq",  32'(irq_o),    32'h1);
    seen_req = '0;
    n_irq = 0;
    repeat (5) begin
      applyStimulus('0, 1'b0, 1'b0);
      seen_req |= resync_req_o;
      if (irq_o) n_irq++;
    end
    checkOutput("unc_no_req",   32'(seen_req),     32'h0);
    checkOutput("unc_irq_once", 32'(n_irq),        32'd0);
    checkOutput("unc_no_fault", 32'(fault_perm_o), 32'h0);

    // Round-robin over flat indices 0, 5, 9
    $display("[TB] round robin");
    doReset();
    applyStimulus(12'h221, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rr_g0_req", 32'(resync_req_o), 32'b0001);
    checkOutput("rr_g0_rep", 32'(resync_rep_o), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("rr_g0_drop", 32'(resync_req_o), 32'h0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rr_g5_req", 32'(resync_req_o), 32'b0010);
    checkOutput("rr_g5_rep", 32'(resync_rep_o), 32'd2);
    applyStimulus(12'h001, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("rr_g5_drop", 32'(resync_req_o), 32'h0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rr_g9_req", 32'(resync_req_o), 32'b1000);
    checkOutput("rr_g9_rep", 32'(resync_rep_o), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rr_g0b_req", 32'(resync_req_o), 32'b0001);
    checkOutput("rr_g0b_rep", 32'(resync_rep_o), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus(12'h001, 1'b0, 1'b1);
    checkOutput("rr_ack_cycle_drop", 32'(resync_req_o), 32'h0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rr_set_wins", 32'(resync_req_o), 32'b0001);
    applyStimulus('0, 1'b0, 1'b1);
    seen_req = '0;
    repeat (4) begin
      applyStimulus('0, 1'b0, 1'b0);
      seen_req |= resync_req_o;
    end
    checkOutput("rr_all_done", 32'(seen_req), 32'h0);

    // Clear during REQ with sticky state present
    $display("[TB] clear mid-request");
    doReset();
    repeat (8) begin
      applyStimulus(12'h002, 1'b0, 1'b1);
      applyStimulus('0, 1'b0, 1'b1);
    end
    repeat (4) applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(12'h018, 1'b0, 1'b0);
    applyStimulus(12'h400, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("clr_pre_req",    32'(resync_req_o), 32'b1000);
    checkOutput("clr_pre_rep",    32'(resync_rep_o), 32'd1);
    checkOutput("clr_pre_fault",  32'(fault_perm_o), 32'h002);
    checkOutput("clr_pre_uncorr", 32'(uncorr_o),     32'b0010);
    applyStimulus(12'h800, 1'b1, 1'b1);
    checkOutput("clr_req",    32'(resync_req_o), 32'h0);
    checkOutput("clr_fault",  32'(fault_perm_o), 32'h0);
    checkOutput("clr_en",     32'(replica_en_o), 32'hFFF);
    checkOutput("clr_uncorr", 32'(uncorr_o),     32'h0);
    checkOutput("clr_irq",    32'(irq_o),        32'h0);
    seen_req = '0;
    repeat (4) begin
      applyStimulus('0, 1'b0, 1'b0);
      seen_req |= resync_req_o;
    end
    checkOutput("clr_err_discarded", 32'(seen_req), 32'h0);

    // Reset during REQ
    $display("[TB] reset mid-request");
    applyStimulus(12'h001, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("rstq_pre_req", 32'(resync_req_o), 32'b0001);
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rstq_req", 32'(resync_req_o), 32'h0);
    seen_req = '0;
    repeat (4) begin
      applyStimulus('0, 1'b0, 1'b0);
      seen_req |= resync_req_o;
    end
    checkOutput("rstq_pending_gone", 32'(seen_req), 32'h0);

    // No ack: timeout drops the request, or it waits forever without the feature
    $display("[TB] missing ack");
    doReset();
    applyStimulus(12'h020, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("tmo_grant_req", 32'(resync_req_o), 32'b0010);
    checkOutput("tmo_grant_rep", 32'(resync_rep_o), 32'd2);
    n_miss = 0;
`ifdef FT_RESYNC_TIMEOUT_EN
    repeat (63) begin
      applyStimulus('0, 1'b0, 1'b0);
      if (resync_req_o !== 4'b0010) n_miss++;
    end
    checkOutput("tmo_held", 32'(n_miss), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("tmo_drop",  32'(resync_req_o), 32'h0);
    checkOutput("tmo_fault", 32'(fault_perm_o), 32'h020);
    checkOutput("tmo_en",    32'(replica_en_o), 32'hFDF);
    checkOutput("tmo_irq",   32'(irq_o),        32'h1);
`else
    repeat (200) begin
      applyStimulus('0, 1'b0, 1'b0);
      if (resync_req_o !== 4'b0010) n_miss++;
    end
    checkOutput("wait_held",  32'(n_miss),       32'd0);
    checkOutput("wait_fault", 32'(fault_perm_o), 32'h0);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("wait_drop",  32'(resync_req_o), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
